// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//
// Program loader for the single-cycle MIPS core. Bytes arrive over a
// valid/ready handshake and are packed big-endian into 32-bit instruction
// words. Each word is written to program memory at consecutive word
// addresses, starting from 0. The processor is held in reset for the whole
// session. Every word's opcode field is checked against the opcodes the
// control unit decodes. Unsupported opcodes raise a sticky error flag, and
// the address of the first offending word is recorded.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_start        begin a load session (sampled only when idle)
//   i_word_count   number of words to load, clamped to the memory depth
//   i_byte_in      stream byte
//   i_byte_valid   stream byte valid
//   o_byte_ready   a byte is accepted this cycle if i_byte_valid is high
//   o_mem_we       program-memory write strobe, one cycle per word
//   o_mem_addr     word address of the write
//   o_mem_wdata    assembled instruction word
//   o_cpu_hold     holds the processor in reset while high
//   o_busy         session in progress
//   o_done         one-cycle pulse at the end of a session
//   o_err_opcode   sticky: an unsupported opcode was loaded
//   o_err_addr     address of the first unsupported word
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_opcode,
  output logic [ADDR_WIDTH-1:0] o_err_addr
);

  // Memory depth expressed in the word-count width (one extra bit so that a
  // full memory's worth of words is representable).
  localparam logic [ADDR_WIDTH:0] MAX_N   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [ADDR_WIDTH:0]   r_n;          // words to load this session
  logic [ADDR_WIDTH:0]   r_word_idx;   // index of the word being assembled
  logic [1:0]            r_byte_cnt;   // bytes collected for current word
  logic [31:0]           r_word;       // big-endian assembly register
  logic                  r_err_opcode;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic                  w_accept;
  logic                  w_last_word;
  logic [ADDR_WIDTH:0]   w_n_clamped;
  logic                  w_opcode_ok;

  // Ready is decoded from state only, so accept needs no input-to-output path.
  assign w_accept    = (r_state == S_RECV) && i_byte_valid;
  assign w_last_word = ((r_word_idx + IDX_ONE) == r_n);
  assign w_n_clamped = (i_word_count > MAX_N) ? MAX_N : i_word_count;

  // Opcodes decoded by the core's control unit.
  always_comb begin
    w_opcode_ok = 1'b0;
    case (r_word[31:26])
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
      6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: w_opcode_ok = 1'b1;
      default:                           w_opcode_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_word_count == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_we     = 1'b1;
        o_busy       = 1'b1;
        w_state_next = w_last_word ? S_DONE : S_RECV;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_busy       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: word assembly, word index and opcode error tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_n          <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_err_opcode <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_n          <= w_n_clamped;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_err_opcode <= 1'b0;
            r_err_addr   <= '0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            // Earlier bytes shift toward the MSB; the 4th lands in [7:0].
            r_word     <= {r_word[23:0], i_byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          r_word_idx <= r_word_idx + IDX_ONE;
          if (!w_opcode_ok) begin
            r_err_opcode <= 1'b1;
            if (!r_err_opcode) begin
              r_err_addr <= r_word_idx[ADDR_WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mem_addr   = r_word_idx[ADDR_WIDTH-1:0];
  assign o_mem_wdata  = r_word;
  assign o_cpu_hold   = o_busy;
  assign o_err_opcode = r_err_opcode;
  assign o_err_addr   = r_err_addr;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
//
// Randomized self-checking bench for instr_loader. The driver computes the
// expected memory writes and end-of-session error status from a word image
// and pushes them into queues; a monitor on the falling clock edge pops and
// compares whenever the loader writes memory or pulses done.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic          i_start;
  logic [AW:0]   i_word_count;
  logic [7:0]    i_byte_in;
  logic          i_byte_valid;
  logic          o_byte_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_cpu_hold;
  logic          o_busy;
  logic          o_done;
  logic          o_err_opcode;
  logic [AW-1:0] o_err_addr;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_word_count (i_word_count),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err_opcode (o_err_opcode),
    .o_err_addr   (o_err_addr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          gap;       // required cycles since previous write, 0 = any
  } wr_t;

  typedef struct {
    int   n;
    logic err;
    int   err_addr;
    int   start_cyc;
  } dn_t;

  wr_t         wr_q[$];
  dn_t         dn_q[$];
  logic [31:0] img [0:DEPTH-1];
  int          sess_writes = 0;
  int          last_we     = -100;
  bit          idle_check  = 1'b0;

  logic [5:0] sup_ops [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                               6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  endtask

  task automatic timeout_fail(input string what);
    n_compared++;
    n_mismatched++;
    $display("FAIL timeout %s: got no progress expected completion (cycle %0d)", what, cyc);
    summary_and_finish();
  endtask

  function automatic bit op_supported(input logic [5:0] op);
    foreach (sup_ops[k]) if (sup_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int clamp_n(input int wc);
    return (wc > DEPTH) ? DEPTH : wc;
  endfunction

  // Monitor: consumes expectations as the loader presents writes and done.
  always @(negedge clk) begin
    if (idle_check) begin
      chk("busy_low_after_done", {31'd0, o_busy}, 32'd0);
      chk("hold_low_after_done", {31'd0, o_cpu_hold}, 32'd0);
      idle_check = 1'b0;
    end
    if (o_mem_we) begin
      if (wr_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected none", o_mem_addr, o_mem_wdata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)", o_mem_addr, o_mem_wdata, e.addr, e.data);
        chk("mem_addr", {26'd0, o_mem_addr}, e.addr);
        chk("mem_wdata", o_mem_wdata, e.data);
        chk("ready_in_write", {31'd0, o_byte_ready}, 32'd0);
        chk("hold_in_write", {31'd0, o_cpu_hold}, 32'd1);
        if (e.gap != 0) chk("write_gap", cyc - last_we, e.gap);
      end
      last_we = cyc;
      sess_writes++;
    end
    if (o_done) begin
      if (dn_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
      end else begin
        dn_t d;
        d = dn_q.pop_front();
        $display("done n=%0d writes=%0d err=%0b err_addr=%0d", d.n, sess_writes, o_err_opcode, o_err_addr);
        chk("done_err_opcode", {31'd0, o_err_opcode}, {31'd0, d.err});
        chk("done_err_addr", {26'd0, o_err_addr}, d.err_addr);
        chk("done_write_count", sess_writes, d.n);
        chk("done_ready", {31'd0, o_byte_ready}, 32'd0);
        if (d.n == 0) chk("done_cycle_n0", cyc, d.start_cyc);
        else          chk("done_cycle", cyc, last_we + 1);
      end
      sess_writes = 0;
      idle_check  = 1'b1;
    end
  end

  task automatic apply_reset();
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    @(negedge clk);
    chk("rst_byte_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("rst_mem_addr", {26'd0, o_mem_addr}, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_cpu_hold", {31'd0, o_cpu_hold}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_err_opcode", {31'd0, o_err_opcode}, 32'd0);
    chk("rst_err_addr", {26'd0, o_err_addr}, 32'd0);
    i_reset     = 1'b0;
    sess_writes = 0;
    last_we     = -100;
    idle_check  = 1'b0;
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid.
  // abort_at >= 0 applies reset once that many bytes have been accepted.
  // glitch pulses start randomly while the session is receiving.
  task automatic run_session(input int wc, input int mode, input int abort_at, input bit glitch);
    int          n;
    int          idx;
    int          err_w;
    int          budget;
    bit          v;
    logic [31:0] w;
    dn_t         d;
    wr_t         e;
    n     = clamp_n(wc);
    err_w = -1;
    for (int k = 0; k < n; k++) begin
      if (err_w < 0 && !op_supported(img[k][31:26])) err_w = k;
    end
    $display("session word_count=%0d n=%0d mode=%0d abort=%0d glitch=%0b", wc, n, mode, abort_at, glitch);
    if (!(abort_at >= 0 && abort_at < 4 * n)) begin
      d.n         = n;
      d.err       = (err_w >= 0);
      d.err_addr  = (err_w >= 0) ? err_w : 0;
      d.start_cyc = cyc + 1;
      dn_q.push_back(d);
    end
    i_start      = 1'b1;
    i_word_count = wc[AW:0];
    @(negedge clk);
    i_start = 1'b0;
    chk("start_busy", {31'd0, o_busy}, 32'd1);
    chk("start_hold", {31'd0, o_cpu_hold}, 32'd1);
    chk("start_ready", {31'd0, o_byte_ready}, (n > 0) ? 32'd1 : 32'd0);
    chk("start_err_clear", {31'd0, o_err_opcode}, 32'd0);
    chk("start_err_addr_clear", {26'd0, o_err_addr}, 32'd0);
    idx    = 0;
    budget = 0;
    while (idx < 4 * n) begin
      if (abort_at >= 0 && idx == abort_at) begin
        apply_reset();
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      w            = img[idx / 4];
      i_byte_valid = v;
      i_byte_in    = v ? w[8 * (3 - idx % 4) +: 8] : 8'($urandom);
      if (glitch) begin
        i_start      = 1'($urandom_range(0, 1));
        i_word_count = 7'($urandom);
      end
      if (v && o_byte_ready) begin
        if (idx % 4 == 3) begin
          e.addr = idx / 4;
          e.data = img[idx / 4];
          e.gap  = (mode == 0 && idx / 4 > 0) ? 5 : 0;
          wr_q.push_back(e);
        end
        idx++;
      end
      @(negedge clk);
      budget++;
      if (budget > 4000) timeout_fail("byte_accept");
    end
    i_start = 1'b0;
    // Keep a byte on offer through WRITE, DONE and IDLE; it must not be taken.
    i_byte_valid = 1'b1;
    i_byte_in    = 8'hA5;
    budget       = 0;
    while (o_busy) begin
      @(negedge clk);
      budget++;
      if (budget > 20) timeout_fail("session_end");
    end
    @(negedge clk);
    chk("idle_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("end_err_opcode", {31'd0, o_err_opcode}, (err_w >= 0) ? 32'd1 : 32'd0);
    chk("end_err_addr", {26'd0, o_err_addr}, (err_w >= 0) ? err_w : 0);
    i_byte_valid = 1'b0;
  endtask

  task automatic fill_random(input int cnt, input int bad_one_in);
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(1, bad_one_in) == 1) img[k] = $urandom;
      else img[k] = {sup_ops[$urandom_range(0, 10)], 26'($urandom)};
    end
  endtask

  initial begin
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_word_count = '0;
    i_byte_in    = '0;
    i_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();

    // Directed two-word image, full rate then toggling valid.
    img[0] = 32'h2008_0005;
    img[1] = 32'h0000_0000;
    run_session(2, 0, -1, 1'b0);
    run_session(2, 1, -1, 1'b0);

    // Unsupported opcode in the middle word.
    img[0] = 32'h8C01_0004;
    img[1] = 32'hFC00_0000;
    img[2] = 32'hAC02_0008;
    run_session(3, 0, -1, 1'b0);

    // Following session clears the error.
    fill_random(4, 1000000);
    run_session(4, 2, -1, 1'b0);

    // Empty session.
    run_session(0, 0, -1, 1'b0);

    // Oversized count clamps to the memory depth.
    fill_random(DEPTH, 16);
    run_session(127, 0, -1, 1'b0);

    // Reset two bytes into the second word, then a clean reload.
    fill_random(3, 4);
    run_session(3, 0, 6, 1'b0);
    fill_random(3, 4);
    run_session(3, 2, -1, 1'b0);

    // start pulsed while receiving has no effect.
    fill_random(4, 4);
    run_session(4, 0, -1, 1'b1);

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      fill_random(16, 6);
      run_session($urandom_range(0, 12), $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("write_queue_drained", wr_q.size(), 32'd0);
    chk("done_queue_drained", dn_q.size(), 32'd0);
    summary_and_finish();
  end

endmodule
